// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential reads to a one-cycle instruction memory,
// queues returned words with their PCs, and hands them to decode over valid/ready.
module instruction_fetch_unit #(
   parameter int                  INSTRUCTION_LEN = 32,
   parameter int                  ADDR_LEN        = 32,
   parameter int                  QUEUE_DEPTH     = 4,
   parameter logic [ADDR_LEN-1:0] RESET_PC        = {ADDR_LEN{1'b0}}
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic [ADDR_LEN-1:0]              mem_address,
   output logic                             mem_read,
   input  logic [INSTRUCTION_LEN-1:0]       mem_read_data,
   input  logic                             branch_taken,
   input  logic [ADDR_LEN-1:0]              branch_address,
   input  logic                             instr_ready,
   output logic                             instr_valid,
   output logic [INSTRUCTION_LEN-1:0]       instr,
   output logic [ADDR_LEN-1:0]              instr_pc,
   output logic [$clog2(QUEUE_DEPTH):0]     queue_count
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_LEN-1:0]        fetch_pc_r;
   logic [ADDR_LEN-1:0]        inflight_pc_r;
   logic                       inflight_r;
   logic [PTR_W-1:0]           head_r;
   logic [PTR_W-1:0]           tail_r;
   logic [CNT_W-1:0]           count_r;
   logic [INSTRUCTION_LEN-1:0] instr_mem_r [QUEUE_DEPTH];
   logic [ADDR_LEN-1:0]        pc_mem_r    [QUEUE_DEPTH];

   logic [CNT_W-1:0]           occupancy_s;
   logic                       issue_s;
   logic                       push_s;
   logic                       pop_s;

   // Issue/push/pop decisions; the in-flight word reserves a slot so the queue never overflows.
   always_comb begin
      occupancy_s = count_r + CNT_W'(inflight_r);
      issue_s     = rst && !branch_taken && (occupancy_s < CNT_W'(QUEUE_DEPTH));
      push_s      = inflight_r && !branch_taken;
      pop_s       = (count_r != {CNT_W{1'b0}}) && instr_ready && !branch_taken;
   end

   // Memory request side and head presentation; empty queue shows zeros.
   always_comb begin
      mem_address = fetch_pc_r;
      mem_read    = issue_s;
      queue_count = count_r;
      instr_valid = (count_r != {CNT_W{1'b0}});
      if (instr_valid) begin
         instr    = instr_mem_r[head_r];
         instr_pc = pc_mem_r[head_r];
      end else begin
         instr    = {INSTRUCTION_LEN{1'b0}};
         instr_pc = {ADDR_LEN{1'b0}};
      end
   end

   // Fetch PC, in-flight tracking and queue pointers; a branch flushes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_r    <= RESET_PC;
         inflight_r    <= 1'b0;
         inflight_pc_r <= {ADDR_LEN{1'b0}};
         head_r        <= {PTR_W{1'b0}};
         tail_r        <= {PTR_W{1'b0}};
         count_r       <= {CNT_W{1'b0}};
      end else if (branch_taken) begin
         fetch_pc_r <= branch_address & {{(ADDR_LEN-2){1'b1}}, 2'b00};
         inflight_r <= 1'b0;
         head_r     <= {PTR_W{1'b0}};
         tail_r     <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
      end else begin
         if (issue_s) begin
            fetch_pc_r    <= fetch_pc_r + ADDR_LEN'(32'd4);
            inflight_pc_r <= fetch_pc_r;
            inflight_r    <= 1'b1;
         end else begin
            inflight_r    <= 1'b0;
         end
         if (push_s) begin
            tail_r <= tail_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            head_r <= head_r + PTR_W'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Queue storage is data-only and needs no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         instr_mem_r[tail_r] <= mem_read_data;
         pc_mem_r[tail_r]    <= inflight_pc_r;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table-driven backpressure vectors,
// a PC/instruction scoreboard, and directed branch, reset and PC-wrap sequences.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic        branch_taken;
   logic [31:0] branch_address;
   logic        instr_ready;

   logic [31:0] mem_address, mem_read_data, instr, instr_pc;
   logic        mem_read, instr_valid;
   logic [2:0]  queue_count;

   logic [31:0] mem_address_w, mem_read_data_w, instr_w, instr_pc_w;
   logic        mem_read_w, instr_valid_w;
   logic [2:0]  queue_count_w;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        rdy;
      logic        mrd;
      logic [31:0] addr;
      logic [2:0]  cnt;
      logic        vld;
   } vec_t;
   vec_t tbl[12];

   instruction_fetch_unit u_dut (
      .clk(clk), .rst(rst),
      .mem_address(mem_address), .mem_read(mem_read), .mem_read_data(mem_read_data),
      .branch_taken(branch_taken), .branch_address(branch_address),
      .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .queue_count(queue_count)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_w (
      .clk(clk), .rst(rst),
      .mem_address(mem_address_w), .mem_read(mem_read_w), .mem_read_data(mem_read_data_w),
      .branch_taken(branch_taken), .branch_address(branch_address),
      .instr_ready(instr_ready), .instr_valid(instr_valid_w), .instr(instr_w),
      .instr_pc(instr_pc_w), .queue_count(queue_count_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Big-endian byte memory contents, derived from the byte address.
   function automatic logic [7:0] byte_at(input logic [31:0] a);
      return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {byte_at(a), byte_at(a + 32'd1), byte_at(a + 32'd2), byte_at(a + 32'd3)};
   endfunction

   // Instruction memory models: ReadData registered on the edge that samples MemRead.
   always @(posedge clk) begin
      if (mem_read) mem_read_data <= word_at(mem_address);
      if (mem_read_w) mem_read_data_w <= word_at(mem_address_w);
   end

   // Queue can never exceed its depth.
   always @(negedge clk) begin
      if (rst) begin
         assert (queue_count <= 3'd4) else $error("FAIL overflow: count %0d exceeds 4", queue_count);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic refill(input logic [31:0] pc0);
      sb.delete();
      for (int i = 0; i < 40; i++) begin
         exp_t e;
         e.pc   = pc0 + 32'(4 * i);
         e.word = word_at(e.pc);
         sb.push_back(e);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then check the presented head against the scoreboard.
   task automatic step(input logic r, input logic rdy, input logic br, input logic [31:0] ba);
      @(negedge clk);
      rst = r; instr_ready = rdy; branch_taken = br; branch_address = ba;
      #1;
      if (r && !br && instr_valid) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            chk("instr_pc", instr_pc, sb[0].pc);
            chk("instr", instr, sb[0].word);
            if (rdy) void'(sb.pop_front());
         end
      end
      if (br) refill({ba[31:2], 2'b00});
   endtask

   task automatic reset_checks();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_count", 32'(queue_count), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_w_count", 32'(queue_count_w), 32'd0);
      chk("rst_w_valid", 32'(instr_valid_w), 32'd0);
   endtask

   task automatic apply_reset();
      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      reset_checks();
   endtask

   initial begin
      rst = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; branch_address = 32'd0;
      mem_read_data = 32'd0; mem_read_data_w = 32'd0;

      //                rdy   mrd   addr          cnt   vld
      tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 3'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 32'h0000_0004, 3'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 32'h0000_0008, 3'd1, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 32'h0000_000C, 3'd2, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 32'h0000_0010, 3'd3, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 32'h0000_0010, 3'd4, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 32'h0000_0010, 3'd4, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 32'h0000_0010, 3'd4, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 32'h0000_0010, 3'd3, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 32'h0000_0014, 3'd2, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 32'h0000_0018, 3'd2, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 32'h0000_001C, 3'd2, 1'b1};

      // Reset then stream with decode always ready.
      apply_reset();
      refill(32'h0);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'd0);
         chk("stream_valid", 32'(instr_valid), (i >= 2) ? 32'd1 : 32'd0);
         if (i == 0) chk("first_addr", mem_address, 32'h0);
         chk("stream_mem_read", 32'(mem_read), 32'd1);
      end

      // Branch with a word in flight and a pop pending.
      step(1'b1, 1'b1, 1'b1, 32'h0000_0043);
      chk("br_no_issue", 32'(mem_read), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("br_count", 32'(queue_count), 32'd0);
      chk("br_valid0", 32'(instr_valid), 32'd0);
      chk("br_addr", mem_address, 32'h40);
      chk("br_mem_read", 32'(mem_read), 32'd1);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("br_valid1", 32'(instr_valid), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("br_valid2", 32'(instr_valid), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

      // Backpressure from reset, then drain.
      apply_reset();
      refill(32'h0);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, tbl[i].rdy, 1'b0, 32'd0);
         chk($sformatf("bp_mem_read[%0d]", i), 32'(mem_read), 32'(tbl[i].mrd));
         chk($sformatf("bp_addr[%0d]", i), mem_address, tbl[i].addr);
         chk($sformatf("bp_count[%0d]", i), 32'(queue_count), 32'(tbl[i].cnt));
         chk($sformatf("bp_valid[%0d]", i), 32'(instr_valid), 32'(tbl[i].vld));
      end

      // Asynchronous reset between edges with three entries queued.
      apply_reset();
      refill(32'h0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("pre_arst_count", 32'(queue_count), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      reset_checks();
      step(1'b0, 1'b0, 1'b0, 32'd0);
      refill(32'h0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("arst_restart_addr", mem_address, 32'h0);
      chk("arst_restart_rd", 32'(mem_read), 32'd1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

      // PC wrap on the instance that starts at 0xFFFFFFF8.
      apply_reset();
      refill(32'h0);
      for (int i = 0; i < 6; i++) begin
         logic [31:0] exp_a;
         logic [31:0] exp_p;
         step(1'b1, 1'b1, 1'b0, 32'd0);
         exp_a = 32'hFFFF_FFF8 + 32'(4 * i);
         if (i < 4) chk($sformatf("wrap_addr[%0d]", i), mem_address_w, exp_a);
         if (i >= 2) begin
            exp_p = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
            chk($sformatf("wrap_valid[%0d]", i), 32'(instr_valid_w), 32'd1);
            chk($sformatf("wrap_pc[%0d]", i), instr_pc_w, exp_p);
            chk($sformatf("wrap_instr[%0d]", i), instr_w, word_at(exp_p));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Read-side initiator for the byte-addressed, big-endian instruction memory.
- Drives the memory's address and MemRead inputs and captures the 32-bit ReadData one cycle later.
- Buffers fetched words with their PCs in a small queue and presents them to the decode stage through a valid/ready handshake.
- Redirects fetch on a taken branch, flushing all queued and in-flight words.

Parameters:
- INSTRUCTION_LEN, 32, instruction and data word width.
- ADDR_LEN, 32, byte-address and PC width.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset; word-aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_address  out  ADDR_LEN  byte address to instruction memory.
- mem_read  out  1  read request to instruction memory (its MemRead).
- mem_read_data  in  INSTRUCTION_LEN  memory ReadData; valid the cycle after the request.
- branch_taken  in  1  redirect request from execute.
- branch_address  in  ADDR_LEN  redirect target; bits [1:0] forced to 0.
- instr_ready  in  1  decode accepts the head entry this cycle.
- instr_valid  out  1  queue head valid.
- instr  out  INSTRUCTION_LEN  head instruction word.
- instr_pc  out  ADDR_LEN  byte address of the head instruction.
- queue_count  out  clog2(QUEUE_DEPTH)+1  occupied entries.

Behaviour:

Reset (rst low, asynchronous):
- fetch_pc = RESET_PC; queue empty; in-flight flag cleared.
- instr_valid = 0, instr = 0, instr_pc = 0, queue_count = 0.
- mem_read is gated by rst, so it is 0 immediately.

Memory timing:
- The memory registers ReadData on the edge where it samples mem_read = 1.
- A request issued in cycle c returns data in cycle c+1.
- The unit writes that data into the queue at the end of cycle c+1, tagged with the requested PC.

Issue:
- mem_address = fetch_pc (combinational).
- issue = rst && !branch_taken && (queue_count + inflight < QUEUE_DEPTH); mem_read = issue.
- Pops in the same cycle are not credited toward space.
- On issue: inflight <= 1; inflight_pc <= fetch_pc; fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_LEN (0xFFFFFFFC -> 0x0).
- With no issue: inflight <= 0.

Capture:
- If inflight = 1 and no branch this cycle, push {mem_read_data, inflight_pc} at the queue tail.
- Capacity is guaranteed by the issue rule; overflow is impossible and is flagged by a bench assertion.

Handshake:
- instr_valid = (queue_count != 0); instr and instr_pc come from the head.
- pop = instr_valid && instr_ready.
- Push and pop in the same cycle leave the count unchanged.
- Popping an empty queue has no effect.
- While instr_valid = 1 and instr_ready = 0, instr and instr_pc hold stable.

Branch (branch_taken = 1 at an edge):
- Queue cleared (count = 0).
- inflight <= 0; the word returning next cycle from any earlier request is discarded.
- fetch_pc <= {branch_address[ADDR_LEN-1:2], 2'b00}; no request that cycle.
- Branch wins over a simultaneous push or pop.
- Fetch from the target issues the following cycle; its instruction is valid 2 cycles after the branch edge.

Latency and throughput:
- After rst rises, the first request issues that cycle; instr_valid rises 2 edges later.
- Sustained throughput is 1 instruction/cycle with instr_ready held high.

Reset mid-operation:
- Asynchronous clear of all state; any pending memory response is ignored.

Queue storage:
- Circular buffer with head/tail pointers wrapping at QUEUE_DEPTH.
- Storage contents are not reset; only pointers and count are.

Test Plan:
- Reset then stream: memory preloaded with words W0..W7 at 0x0..0x1C, instr_ready = 1 -> instr_valid rises 2 cycles after reset release; instr/instr_pc = (W0,0x0),(W1,0x4)... one per cycle, no gaps.
- Backpressure: instr_ready = 0 from reset -> mem_read issues exactly 4 requests (0x0..0xC) then stays 0; queue_count = 4; instr = W0 held stable; raising instr_ready drains the queue in order and fetch resumes at 0x10.
- Branch flush with in-flight: mid-stream, branch_taken = 1 with branch_address = 0x43 -> queue_count = 0 next cycle; next request at 0x40; the in-flight word is never presented; next instr_pc = 0x40.
- Simultaneous branch and pop/push: branch asserted while instr_ready = 1 and a response is returning -> no stale word is delivered; the branch target is the first delivered instruction.
- Asynchronous reset mid-stream: rst low between edges with 3 entries queued -> instr_valid, queue_count and mem_read drop to 0 immediately; after release, fetch restarts at RESET_PC.
- PC wrap: RESET_PC = 0xFFFFFFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, with instr_pc matching each.
